// File: rtl/gf_mult_exp_seq_if.sv
// gf_mult_exp_seq_if
// Handshake and operand bus for the sequential GF multiply/exponent unit.
//   start     request, taken only while the unit is not busy
//   op        00 int mult, 01 carry-less mult, 10 GF mult mod poly, 11 GF exp
//   a, b      operands (b is also the exponent in op 11)
//   poly      reduction polynomial without the implicit x^W term
//   busy      operation in flight
//   done      one-cycle pulse when out/mult_out are refreshed
//   out       low W bits of the result
//   mult_out  full 2W product (ops 00/01) or zero-extended field element
// The master drives requests, the slave is the arithmetic unit.
interface gf_mult_exp_seq_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                      start;
    logic [1:0]                op;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [DATA_WIDTH-1:0]     poly;
    logic                      busy;
    logic                      done;
    logic [DATA_WIDTH-1:0]     out;
    logic [2*DATA_WIDTH-1:0]   mult_out;

    modport master (
        output start, op, a, b, poly,
        input  busy, done, out, mult_out
    );

    modport slave (
        input  start, op, a, b, poly,
        output busy, done, out, mult_out
    );
endinterface

// File: rtl/gf_mult_exp_seq.sv
// gf_mult_exp_seq
// Bit-serial integer / carry-less / GF(2^W) multiplier with constant-time
// GF(2^W) exponentiation (square-and-multiply) behind a start/busy/done
// handshake. One step of the shared multiplier core runs per clock.
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset, aborts any operation in flight
//   bus   gf_mult_exp_seq_if slave modport (start/op/a/b/poly in,
//         busy/done/out/mult_out out)
// Latency from the accepting edge: W+1 cycles for ops 00/01/10 and
// 2*W*EXP_WIDTH+1 cycles for op 11, independent of operand values.
module gf_mult_exp_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    gf_mult_exp_seq_if.slave bus
);

    localparam int W   = DATA_WIDTH;
    localparam int E   = EXP_WIDTH;
    localparam int CW  = $clog2(W) + 1;
    localparam int EIW = (E > 1) ? $clog2(E) : 1;

    localparam logic [1:0] OP_INT = 2'b00;
    localparam logic [1:0] OP_CL  = 2'b01;
    localparam logic [1:0] OP_GF  = 2'b10;
    localparam logic [1:0] OP_EXP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        EXP_SQ,
        EXP_MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]       op_l;
    logic [W-1:0]     a_l;
    logic [E-1:0]     b_l;
    logic [W-1:0]     poly_l;
    logic [CW-1:0]    cnt;
    logic [EIW-1:0]   bit_idx;

    // acc holds the 2W integer/carry-less product or, in its low W bits, the
    // running GF remainder; x is the multiplicand, y the multiplier shifter.
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   x;
    logic [W-1:0]     y;
    logic [W-1:0]     r;

    logic [W-1:0]     out_r;
    logic [2*W-1:0]   mult_out_r;

    logic             can_accept;
    logic             phase_end;
    logic             count_end;
    logic             last_bit;
    logic             exp_bit;
    logic [2*W-1:0]   addend;
    logic [2*W-1:0]   int_step;
    logic [2*W-1:0]   cl_step;
    logic [W-1:0]     gf_shift;
    logic [W-1:0]     gf_step;
    logic [W-1:0]     r_sel;

    assign can_accept = (state == IDLE) || (state == DONE);
    assign phase_end  = (cnt == CW'(W - 1));
    assign count_end  = (cnt == CW'(W));
    assign last_bit   = (bit_idx == '0);
    assign exp_bit    = b_l[bit_idx];

    // One step of each multiplier flavour. The GF step shifts the remainder
    // left, folds the overflowing x^W term back in through poly, and then
    // adds the multiplicand when the current (MSB-first) multiplier bit is set.
    always_comb begin
        addend   = y[0] ? x : '0;
        int_step = acc + addend;
        cl_step  = acc ^ addend;
        gf_shift = acc[W-1:0] << 1;
        gf_step  = gf_shift ^ (acc[W-1] ? poly_l : '0) ^ (y[W-1] ? x[W-1:0] : '0);
        r_sel    = exp_bit ? gf_step : r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The last exponent bit's multiply phase runs one extra
    // count so the final cycle only publishes the result, matching the
    // multiply ops' W+1 structure.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = (bus.op == OP_EXP) ? EXP_SQ : MUL;
                end else begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                if (count_end) begin
                    state_next = DONE;
                end
            end
            EXP_SQ: begin
                if (phase_end) begin
                    state_next = EXP_MUL;
                end
            end
            EXP_MUL: begin
                if (count_end) begin
                    state_next = DONE;
                end else if (phase_end && !last_bit) begin
                    state_next = EXP_SQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Every exponent bit pays for both the square and the multiply;
    // the multiply result is kept only when the exponent bit is set, so the
    // cycle count never depends on the exponent value.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_l       <= '0;
            a_l        <= '0;
            b_l        <= '0;
            poly_l     <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            acc        <= '0;
            x          <= '0;
            y          <= '0;
            r          <= '0;
            out_r      <= '0;
            mult_out_r <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (can_accept && bus.start) begin
                        op_l    <= bus.op;
                        a_l     <= bus.a;
                        b_l     <= bus.b[E-1:0];
                        poly_l  <= bus.poly;
                        cnt     <= '0;
                        bit_idx <= EIW'(E - 1);
                        acc     <= '0;
                        if (bus.op == OP_EXP) begin
                            r <= W'(1);
                            x <= (2*W)'(1);
                            y <= W'(1);
                        end else begin
                            r <= '0;
                            x <= {{W{1'b0}}, bus.a};
                            y <= bus.b;
                        end
                    end
                end
                MUL: begin
                    if (count_end) begin
                        out_r <= acc[W-1:0];
                        if (op_l == OP_GF) begin
                            mult_out_r <= {{W{1'b0}}, acc[W-1:0]};
                        end else begin
                            mult_out_r <= acc;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (op_l == OP_INT) begin
                            acc <= int_step;
                            x   <= x << 1;
                            y   <= y >> 1;
                        end else if (op_l == OP_CL) begin
                            acc <= cl_step;
                            x   <= x << 1;
                            y   <= y >> 1;
                        end else begin
                            acc <= {{W{1'b0}}, gf_step};
                            y   <= y << 1;
                        end
                    end
                end
                EXP_SQ: begin
                    acc <= {{W{1'b0}}, gf_step};
                    y   <= y << 1;
                    cnt <= cnt + CW'(1);
                    if (phase_end) begin
                        r   <= gf_step;
                        acc <= '0;
                        x   <= {{W{1'b0}}, a_l};
                        y   <= gf_step;
                        cnt <= '0;
                    end
                end
                EXP_MUL: begin
                    if (count_end) begin
                        out_r      <= r;
                        mult_out_r <= {{W{1'b0}}, r};
                    end else begin
                        acc <= {{W{1'b0}}, gf_step};
                        y   <= y << 1;
                        cnt <= cnt + CW'(1);
                        if (phase_end) begin
                            r   <= r_sel;
                            acc <= '0;
                            x   <= {{W{1'b0}}, r_sel};
                            y   <= r_sel;
                            if (!last_bit) begin
                                cnt     <= '0;
                                bit_idx <= bit_idx - EIW'(1);
                            end
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bus.busy     = (state == MUL) || (state == EXP_SQ) || (state == EXP_MUL);
    assign bus.done     = (state == DONE);
    assign bus.out      = out_r;
    assign bus.mult_out = mult_out_r;

endmodule
